// File: rtl/wb_stage.sv
// Writeback stage: retires one instruction per handshake, formats load data,
// drives the register-file write port and keeps the retired-instruction count.

package wb_stage_pkg;
    typedef struct packed {
        logic [4:0]  rd_addr;
        logic [31:0] data;
    } writeback_signals;
endpackage

module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int unsigned INSTRET_W = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4:0]           in_rd_addr,
    input  logic [31:0]          in_result,
    input  logic                 in_is_load,
    input  logic [2:0]           in_funct3,
    input  logic [1:0]           in_addr_lo,
    input  logic                 dmem_rvalid,
    input  logic [31:0]          dmem_rdata,
    input  logic                 dmem_err,
    output writeback_signals     signals_out,
    output logic                 wb_valid,
    output logic                 load_fault,
    output logic [INSTRET_W-1:0] instret
);

    typedef enum logic {
        IDLE,
        WAIT_LOAD
    } state_e;

    state_e                 state_q, state_d;
    logic [4:0]             ld_rd_q, ld_rd_d;
    logic [2:0]             ld_f3_q, ld_f3_d;
    logic [1:0]             ld_alo_q, ld_alo_d;
    writeback_signals       sig_q, sig_d;
    logic                   wb_valid_q, wb_valid_d;
    logic                   load_fault_q, load_fault_d;
    logic [INSTRET_W-1:0]   instret_q, instret_d;

    logic [7:0]             ld_byte;
    logic [15:0]            ld_half;
    logic [31:0]            ld_data;
    logic                   ld_fault;

    // Load alignment, extension and fault detection for the pending load
    always_comb begin
        ld_byte  = dmem_rdata[{ld_alo_q, 3'b000} +: 8];
        ld_half  = ld_alo_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        ld_data  = '0;
        ld_fault = dmem_err;
        case (ld_f3_q)
            3'b000: ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001: begin
                ld_data = {{16{ld_half[15]}}, ld_half};
                if (ld_alo_q[0]) ld_fault = 1'b1;
            end
            3'b010: begin
                ld_data = dmem_rdata;
                if (ld_alo_q != 2'b00) ld_fault = 1'b1;
            end
            3'b100: ld_data = {24'h0, ld_byte};
            3'b101: begin
                ld_data = {16'h0, ld_half};
                if (ld_alo_q[0]) ld_fault = 1'b1;
            end
            default: ld_fault = 1'b1;
        endcase
    end

    // Next-state and registered-output logic; rd_addr stays 0 unless retiring
    always_comb begin
        state_d      = state_q;
        ld_rd_d      = ld_rd_q;
        ld_f3_d      = ld_f3_q;
        ld_alo_d     = ld_alo_q;
        sig_d        = '0;
        wb_valid_d   = 1'b0;
        load_fault_d = 1'b0;
        instret_d    = instret_q + INSTRET_W'(wb_valid_q);
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (in_is_load) begin
                        ld_rd_d  = in_rd_addr;
                        ld_f3_d  = in_funct3;
                        ld_alo_d = in_addr_lo;
                        state_d  = WAIT_LOAD;
                    end else begin
                        sig_d.rd_addr = in_rd_addr;
                        sig_d.data    = in_result;
                        wb_valid_d    = 1'b1;
                    end
                end
            end
            WAIT_LOAD: begin
                if (dmem_rvalid) begin
                    state_d = IDLE;
                    if (ld_fault) begin
                        load_fault_d = 1'b1;
                    end else begin
                        sig_d.rd_addr = ld_rd_q;
                        sig_d.data    = ld_data;
                        wb_valid_d    = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ld_rd_q      <= '0;
            ld_f3_q      <= '0;
            ld_alo_q     <= '0;
            sig_q        <= '0;
            wb_valid_q   <= 1'b0;
            load_fault_q <= 1'b0;
            instret_q    <= '0;
        end else begin
            state_q      <= state_d;
            ld_rd_q      <= ld_rd_d;
            ld_f3_q      <= ld_f3_d;
            ld_alo_q     <= ld_alo_d;
            sig_q        <= sig_d;
            wb_valid_q   <= wb_valid_d;
            load_fault_q <= load_fault_d;
            instret_q    <= instret_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign signals_out = sig_q;
    assign wb_valid    = wb_valid_q;
    assign load_fault  = load_fault_q;
    assign instret     = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed plan cases plus randomized ALU/load traffic
// checked against an arithmetic model of load formatting and retirement.

module tb_wb_stage;
    import wb_stage_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [4:0]       in_rd_addr = '0;
    logic [31:0]      in_result = '0;
    logic             in_is_load = 1'b0;
    logic [2:0]       in_funct3 = '0;
    logic [1:0]       in_addr_lo = '0;
    logic             dmem_rvalid = 1'b0;
    logic [31:0]      dmem_rdata = '0;
    logic             dmem_err = 1'b0;
    writeback_signals signals_out;
    logic             wb_valid;
    logic             load_fault;
    logic [63:0]      instret;

    int          cmp_cnt = 0;
    int          err_cnt = 0;
    logic [63:0] exp_instret = '0;

    wb_stage #(.INSTRET_W(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rd_addr(in_rd_addr), .in_result(in_result),
        .in_is_load(in_is_load), .in_funct3(in_funct3), .in_addr_lo(in_addr_lo),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .dmem_err(dmem_err),
        .signals_out(signals_out), .wb_valid(wb_valid),
        .load_fault(load_fault), .instret(instret)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference load result from the ISA rules, using plain shifts and masks
    function automatic void ref_load(input logic [2:0] f3, input logic [1:0] alo,
                                     input logic [31:0] rdata, input logic err,
                                     output logic fault, output logic [31:0] data);
        int unsigned b, h;
        b = (rdata >> (8 * int'(alo))) & 32'hFF;
        h = (rdata >> (16 * (int'(alo) / 2))) & 32'hFFFF;
        fault = err;
        data  = '0;
        case (f3)
            3'd0: data = (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'd1: begin data = (h >= 32768) ? h + 32'hFFFF_0000 : h; if (int'(alo) % 2 != 0) fault = 1'b1; end
            3'd2: begin data = rdata; if (alo != 2'd0) fault = 1'b1; end
            3'd4: data = b;
            3'd5: begin data = h; if (int'(alo) % 2 != 0) fault = 1'b1; end
            default: fault = 1'b1;
        endcase
    endfunction

    // One load from accept through response, optionally accepting an ALU op in the retire cycle
    task automatic do_load(input string nm, input logic [4:0] rd, input logic [2:0] f3,
                           input logic [1:0] alo, input logic [31:0] rdata, input logic err,
                           input int nwait, input bit chain);
        logic        fault;
        logic [31:0] exp_data;
        logic [4:0]  rd2;
        logic [31:0] res2;
        ref_load(f3, alo, rdata, err, fault, exp_data);
        rd2  = 5'($urandom);
        res2 = $urandom;
        in_valid = 1'b1; in_is_load = 1'b1; in_rd_addr = rd; in_funct3 = f3;
        in_addr_lo = alo; in_result = $urandom;
        tick;
        in_valid = 1'b0; in_is_load = 1'b0;
        for (int i = 0; i <= nwait; i++) begin
            cmp_cnt++;
            if (in_ready !== 1'b0 || wb_valid !== 1'b0 || signals_out.rd_addr !== 5'd0) begin
                err_cnt++;
                $display("FAIL %s wait: in_ready=%b wb_valid=%b rd=%0d, required 0/0/0", nm, in_ready, wb_valid, signals_out.rd_addr);
            end
            if (i < nwait) tick;
        end
        dmem_rvalid = 1'b1; dmem_rdata = rdata; dmem_err = err;
        tick;
        dmem_rvalid = 1'b0; dmem_err = 1'b0; dmem_rdata = $urandom;
        if (chain) begin
            in_valid = 1'b1; in_rd_addr = rd2; in_result = res2;
        end
        cmp_cnt++;
        if (fault) begin
            if (load_fault !== 1'b1 || wb_valid !== 1'b0 || signals_out.rd_addr !== 5'd0 || in_ready !== 1'b1) begin
                err_cnt++;
                $display("FAIL %s fault: load_fault=%b wb_valid=%b rd=%0d in_ready=%b, required 1/0/0/1", nm, load_fault, wb_valid, signals_out.rd_addr, in_ready);
            end
        end else begin
            if (wb_valid !== 1'b1 || load_fault !== 1'b0 || signals_out.rd_addr !== rd ||
                signals_out.data !== exp_data || in_ready !== 1'b1) begin
                err_cnt++;
                $display("FAIL %s write: wb=%b lf=%b {%0d,%h} rdy=%b, required 1/0/{%0d,%h}/1", nm, wb_valid, load_fault, signals_out.rd_addr, signals_out.data, in_ready, rd, exp_data);
            end
        end
        cmp_cnt++;
        if (instret !== exp_instret) begin
            err_cnt++;
            $display("FAIL %s instret_before: got %0d, required %0d", nm, instret, exp_instret);
        end
        if (!fault) exp_instret++;
        tick;
        in_valid = 1'b0;
        if (chain) begin
            cmp_cnt++;
            if (wb_valid !== 1'b1 || signals_out.rd_addr !== rd2 || signals_out.data !== res2 || instret !== exp_instret) begin
                err_cnt++;
                $display("FAIL %s chained_alu: wb=%b {%0d,%h} instret=%0d, required 1/{%0d,%h}/%0d", nm, wb_valid, signals_out.rd_addr, signals_out.data, instret, rd2, res2, exp_instret);
            end
            exp_instret++;
            tick;
        end
        cmp_cnt++;
        if (wb_valid !== 1'b0 || load_fault !== 1'b0 || signals_out.rd_addr !== 5'd0 || instret !== exp_instret) begin
            err_cnt++;
            $display("FAIL %s after: wb=%b lf=%b rd=%0d instret=%0d, required 0/0/0/%0d", nm, wb_valid, load_fault, signals_out.rd_addr, instret, exp_instret);
        end
    endtask

    task automatic test_reset;
        #2 rst_n = 1'b0;
        #1;
        cmp_cnt++;
        if (signals_out !== '0 || wb_valid !== 1'b0 || load_fault !== 1'b0 || instret !== 64'd0 || in_ready !== 1'b1) begin
            err_cnt++;
            $display("FAIL reset: sig=%h wb=%b lf=%b instret=%0d rdy=%b, required 0/0/0/0/1", signals_out, wb_valid, load_fault, instret, in_ready);
        end
        tick; tick;
        rst_n = 1'b1;
        exp_instret = '0;
        tick;
    endtask

    task automatic test_alu_back_to_back;
        logic [4:0]  rds  [3] = '{5'd5, 5'd6, 5'd0};
        logic [31:0] ress [3] = '{32'h11, 32'h22, 32'h33};
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_is_load = 1'b0; in_rd_addr = rds[i]; in_result = ress[i];
            tick;
            cmp_cnt++;
            if (wb_valid !== 1'b1 || signals_out.rd_addr !== rds[i] || signals_out.data !== ress[i] || instret !== exp_instret) begin
                err_cnt++;
                $display("FAIL alu_b2b[%0d]: wb=%b {%0d,%h} instret=%0d, required 1/{%0d,%h}/%0d", i, wb_valid, signals_out.rd_addr, signals_out.data, instret, rds[i], ress[i], exp_instret);
            end
            exp_instret++;
        end
        in_valid = 1'b0;
        tick;
        cmp_cnt++;
        if (wb_valid !== 1'b0 || signals_out.rd_addr !== 5'd0 || instret !== 64'd3) begin
            err_cnt++;
            $display("FAIL alu_b2b_end: wb=%b rd=%0d instret=%0d, required 0/0/3", wb_valid, signals_out.rd_addr, instret);
        end
    endtask

    task automatic test_load_format;
        do_load("lb",  5'd7, 3'b000, 2'd3, 32'h80FF_0000, 1'b0, 4, 1'b0);
        do_load("lbu", 5'd7, 3'b100, 2'd3, 32'h80FF_0000, 1'b0, 4, 1'b0);
        do_load("lh",  5'd8, 3'b001, 2'd2, 32'h8001_1234, 1'b0, 1, 1'b0);
        do_load("lhu", 5'd8, 3'b101, 2'd2, 32'h8001_1234, 1'b0, 0, 1'b0);
        do_load("lw",  5'd9, 3'b010, 2'd0, 32'h8001_1234, 1'b0, 2, 1'b0);
    endtask

    task automatic test_faults;
        do_load("fault_err",   5'd10, 3'b010, 2'd0, 32'hDEAD_BEEF, 1'b1, 2, 1'b0);
        do_load("fault_align", 5'd11, 3'b010, 2'd2, 32'hDEAD_BEEF, 1'b0, 1, 1'b0);
        do_load("fault_f3",    5'd12, 3'b011, 2'd0, 32'hDEAD_BEEF, 1'b0, 0, 1'b0);
    endtask

    task automatic test_back_to_back;
        do_load("load_then_alu", 5'd13, 3'b000, 2'd1, 32'h0000_7F00, 1'b0, 1, 1'b1);
        do_load("fault_then_alu", 5'd14, 3'b001, 2'd1, 32'h1234_5678, 1'b0, 0, 1'b1);
    endtask

    task automatic test_random;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(3) == 0) begin
                dmem_rvalid = 1'b1; dmem_rdata = $urandom;
                tick;
                dmem_rvalid = 1'b0;
                cmp_cnt++;
                if (wb_valid !== 1'b0 || load_fault !== 1'b0 || in_ready !== 1'b1) begin
                    err_cnt++;
                    $display("FAIL rand_idle_rvalid[%0d]: wb=%b lf=%b rdy=%b, required 0/0/1", n, wb_valid, load_fault, in_ready);
                end
            end
            if ($urandom_range(1) == 0) begin
                do_load("rand_load", 5'($urandom), 3'($urandom), 2'($urandom), $urandom,
                        ($urandom_range(7) == 0), int'($urandom_range(3)), bit'($urandom_range(1)));
            end else begin
                logic [4:0]  rd;
                logic [31:0] res;
                rd = 5'($urandom); res = $urandom;
                in_valid = 1'b1; in_is_load = 1'b0; in_rd_addr = rd; in_result = res;
                tick;
                in_valid = 1'b0;
                cmp_cnt++;
                if (wb_valid !== 1'b1 || signals_out.rd_addr !== rd || signals_out.data !== res || instret !== exp_instret) begin
                    err_cnt++;
                    $display("FAIL rand_alu[%0d]: wb=%b {%0d,%h} instret=%0d, required 1/{%0d,%h}/%0d", n, wb_valid, signals_out.rd_addr, signals_out.data, instret, rd, res, exp_instret);
                end
                exp_instret++;
                tick;
            end
        end
    endtask

    task automatic test_reset_mid_wait;
        in_valid = 1'b1; in_is_load = 1'b1; in_rd_addr = 5'd15; in_funct3 = 3'b010; in_addr_lo = 2'd0;
        tick;
        in_valid = 1'b0; in_is_load = 1'b0;
        tick; tick;
        rst_n = 1'b0;
        #1;
        cmp_cnt++;
        if (in_ready !== 1'b1 || wb_valid !== 1'b0 || instret !== 64'd0 || signals_out !== '0) begin
            err_cnt++;
            $display("FAIL reset_mid_wait_async: rdy=%b wb=%b instret=%0d sig=%h, required 1/0/0/0", in_ready, wb_valid, instret, signals_out);
        end
        #2 rst_n = 1'b1;
        exp_instret = '0;
        dmem_rvalid = 1'b1; dmem_rdata = 32'h1234_5678;
        tick;
        dmem_rvalid = 1'b0;
        cmp_cnt++;
        if (wb_valid !== 1'b0 || load_fault !== 1'b0 || signals_out.rd_addr !== 5'd0 || instret !== 64'd0 || in_ready !== 1'b1) begin
            err_cnt++;
            $display("FAIL reset_mid_wait_rvalid: wb=%b lf=%b rd=%0d instret=%0d rdy=%b, required 0/0/0/0/1", wb_valid, load_fault, signals_out.rd_addr, instret, in_ready);
        end
        tick;
    endtask

    task automatic test_instret_wrap;
        force dut.instret_d = '1;
        tick;
        release dut.instret_d;
        cmp_cnt++;
        if (instret !== '1) begin
            err_cnt++;
            $display("FAIL wrap_preload: got %h, required ffffffffffffffff", instret);
        end
        in_valid = 1'b1; in_is_load = 1'b0; in_rd_addr = 5'd3; in_result = 32'hABCD;
        tick;
        in_valid = 1'b0;
        tick;
        cmp_cnt++;
        if (instret !== 64'd0) begin
            err_cnt++;
            $display("FAIL wrap: got %h, required 0", instret);
        end
    endtask

    initial begin
        test_reset;
        test_alu_back_to_back;
        test_load_format;
        test_faults;
        test_back_to_back;
        test_random;
        test_reset_mid_wait;
        test_instret_wrap;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage of the pipelined core, directly upstream of the register file. It takes one retiring instruction per handshake from the memory stage. For loads it waits for the data-memory response, then aligns and sign- or zero-extends the loaded byte, halfword or word. It drives the register file's `writeback_signals` write port, keeps the retired-instruction counter and flags load faults.

## Interface
Parameters:
- `INSTRET_W`, 64: width of the retired-instruction counter.

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  memory stage presents an instruction.
- `in_ready`  out  1  stage can accept an instruction this cycle.
- `in_rd_addr`  in  5  destination register; 0 means no register write.
- `in_result`  in  32  ALU/CSR/link result for non-loads.
- `in_is_load`  in  1  the instruction is a load.
- `in_funct3`  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- `in_addr_lo`  in  2  low bits of the load byte address.
- `dmem_rvalid`  in  1  load response valid, one-cycle pulse.
- `dmem_rdata`  in  32  load response word, little-endian.
- `dmem_err`  in  1  bus error; qualified by `dmem_rvalid`.
- `signals_out`  out  `writeback_signals`  `{rd_addr[4:0], data[31:0]}` into the register file.
- `wb_valid`  out  1  one instruction retires this cycle.
- `load_fault`  out  1  one-cycle pulse on a faulted load.
- `instret`  out  `INSTRET_W`  count of retired instructions.

## Operation
- The register file writes on every edge where `rd_addr != 0`. `signals_out.rd_addr` must therefore be 0 in every cycle without a retirement.
- The state machine has two states, IDLE and WAIT_LOAD.
- IDLE:
  - `in_ready = 1`.
  - On `in_valid && in_ready` with a non-load, capture `rd_addr` and `result`. The following cycle is a retire cycle.
  - On `in_valid && in_ready` with a load, capture `rd_addr`, `funct3` and `addr_lo`, then go to WAIT_LOAD.
  - `dmem_rvalid` is ignored in IDLE.
- WAIT_LOAD:
  - `in_ready = 0`.
  - On `dmem_rvalid`, go to IDLE. The following cycle is a retire cycle with formatted data, or a fault cycle.
- Retire cycle:
  - `wb_valid = 1` and `signals_out` carries the captured rd and data.
  - `instret` increments by 1 at the end of the cycle, including when rd = x0.
- Load formatting:
  - LB/LBU select byte `addr_lo`, i.e. `rdata[8*addr_lo +: 8]`.
  - LH/LHU select halfword `addr_lo[1]`.
  - LW passes `rdata` through.
  - LB and LH sign-extend; LBU and LHU zero-extend.
- Fault cases:
  - The causes are `dmem_err`, a misaligned access (LH/LHU with `addr_lo[0]=1`, LW with `addr_lo != 0`) or an undefined `funct3` (011, 110, 111).
  - On a fault: `load_fault = 1` for one cycle, `rd_addr = 0`, `wb_valid = 0`, and `instret` does not change.
- Counter behaviour:
  - `instret` wraps modulo 2^`INSTRET_W`.

## Timing
- Reset: all of the following take effect asynchronously and immediately.
  - Outputs: `signals_out = {0, 0}`, `wb_valid = 0`, `load_fault = 0`, `instret = 0`, `in_ready = 1`.
  - State: IDLE.
- Reset during WAIT_LOAD: the pending load is dropped and no write occurs. A `dmem_rvalid` arriving after reset is ignored.
- Outputs are registered; `in_ready` is combinational from state.
- Non-load latency: accepted at edge N; `signals_out` is valid in cycle N→N+1; the register file writes at edge N+1.
- Non-load throughput: one instruction per cycle back-to-back.
- Load latency: accepted at edge N; `dmem_rvalid` sampled at edge M > N; write presented in cycle M→M+1.
- Load to next instruction: `in_ready` returns to 1 in the same cycle the load's write is presented. The next accept can therefore coincide with the load's retire cycle.
- `dmem_rvalid` in the same cycle as the load accept is not possible by bus contract and is ignored.

## Test plan
- Reset, then three back-to-back ALU ops (rd = 5/6/0, results `0x11`/`0x22`/`0x33`):
  - `signals_out` = {5,`0x11`}, {6,`0x22`}, {0,`0x33`} on consecutive cycles.
  - `wb_valid` is high for 3 cycles and `instret` = 3.
- LB rd = 7 with `addr_lo = 3`, response `0x80FF_0000` after a 4-cycle wait:
  - `in_ready` is low while waiting.
  - Write is {7, `0xFFFF_FF80`}; LBU in the same case gives `0x0000_0080`.
- LH with `addr_lo = 2`, rdata `0x8001_1234` → `0xFFFF_8001`; LHU → `0x0000_8001`; LW with `addr_lo = 0` → `0x8001_1234`.
- Faults:
  - Load with `dmem_err = 1`: `load_fault` pulses once, no write (`rd_addr = 0`), `instret` unchanged.
  - Repeat with LW at `addr_lo = 2`, and with `funct3 = 011`: same result.
- Assert `rst_n` low mid-WAIT_LOAD, release, then pulse `dmem_rvalid`: no write, `instret = 0`, `in_ready = 1`.
- Preload `instret = 2^64−1` via force, retire one instruction: `instret = 0`.
